// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the round-robin SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_RSP
  } ArbState;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set mask bit at or after ptr
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idw(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      // ptr is always < N, so one subtraction is enough to wrap
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && mask[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - shares one single-port SRAM among N_REQ rdyack requesters, round-robin
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = 10,
  parameter int DW    = 16,
  localparam int IDW  = idw(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          req_rdy,
  output logic [N_REQ-1:0]          req_ack,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0][AW-1:0]  req_addr,
  input  logic [N_REQ-1:0][DW-1:0]  req_wdata,
  output logic                      rsp_rdy,
  input  logic                      rsp_ack,
  output logic [IDW-1:0]            rsp_id,
  output logic [DW-1:0]             rsp_data,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [AW-1:0]             sram_addr,
  output logic [DW-1:0]             sram_wdata,
  input  logic [DW-1:0]             sram_rdata
);

  ArbState          state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rd_id;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             grant_rd;

  // Only writes may overlap a pending response; reads wait for the port to be free again.
  always_comb begin
    elig = '0;
    case (state)
      S_IDLE:  elig = req_rdy;
      S_RSP:   elig = req_rdy & req_we;
      default: elig = '0;
    endcase
    if (i_rst) elig = '0;
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_pick (
    .mask      (elig),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ack    = grant_oh;
  assign sram_ce    = grant_any;
  assign sram_we    = grant_any & req_we[grant_idx];
  assign sram_addr  = req_addr[grant_idx];
  assign sram_wdata = req_wdata[grant_idx];
  assign grant_rd   = grant_any & ~req_we[grant_idx];
  assign rsp_rdy    = (state == S_RSP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_rd) state_nxt = S_RD;
      S_RD:    state_nxt = S_RSP;
      S_RSP:   if (rsp_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      rd_id    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == S_IDLE && grant_rd) begin
        rd_id <= grant_idx;
      end
      // SRAM data is captured once, so later writes to the same address cannot disturb it
      if (state == S_RD) begin
        rsp_data <= sram_rdata;
        rsp_id   <= rd_id;
      end
    end
  end

endmodule
